// File: rtl/display_sched.sv
// display_sched: round-robin time-sharing of a 4-digit 7-segment display
// between three requesters, with a guaranteed minimum hold per owner and
// optional leading-zero blanking of the outgoing BCD word.
module display_sched #(
   parameter int unsigned HOLD_CYCLES = 50000000,
   parameter bit          LZB         = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [15:0] data0,
   input  logic [15:0] data1,
   input  logic [15:0] data2,
   output logic [2:0]  gnt,
   output logic [15:0] disp_num,
   output logic [3:0]  disp_blank,
   output logic        busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HOLD = 2'd1,
      ST_OWN  = 2'd2
   } state_t;

   localparam logic [31:0] HOLD_LOAD = 32'(HOLD_CYCLES - 1);

   state_t      state_q, state_d;
   logic [2:0]  gnt_q, gnt_d;
   logic [1:0]  owner_q, owner_d;
   logic [1:0]  last_q, last_d;
   logic [31:0] cnt_q, cnt_d;
   logic [15:0] num_q, num_d;
   logic [2:0]  pick_idle_s;
   logic [2:0]  pick_own_s;
   logic [3:0]  blank_s;

   // Successor of a requester index in the 0 -> 1 -> 2 -> 0 ring.
   function automatic logic [1:0] rr_next(input logic [1:0] p);
      logic [1:0] n;
      case (p)
         2'd0:    n = 2'd1;
         2'd1:    n = 2'd2;
         default: n = 2'd0;
      endcase
      return n;
   endfunction

   // Round-robin search starting after p; p itself is tried last only when
   // incl_self is set. Returns {found, index}.
   function automatic logic [2:0] pick_rr(input logic [2:0] r, input logic [1:0] p,
                                          input logic incl_self);
      logic [1:0] c1;
      logic [1:0] c2;
      logic [2:0] res;
      c1 = rr_next(p);
      c2 = rr_next(c1);
      if (r[c1]) begin
         res = {1'b1, c1};
      end else if (r[c2]) begin
         res = {1'b1, c2};
      end else if (incl_self && r[p]) begin
         res = {1'b1, p};
      end else begin
         res = 3'b000;
      end
      return res;
   endfunction

   // Data word belonging to a requester index.
   function automatic logic [15:0] sel_data(input logic [1:0] idx, input logic [15:0] d0,
                                            input logic [15:0] d1, input logic [15:0] d2);
      logic [15:0] v;
      case (idx)
         2'd0:    v = d0;
         2'd1:    v = d1;
         default: v = d2;
      endcase
      return v;
   endfunction

   // Next-state logic: arbitration, hold countdown and display word selection.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cnt_d       = cnt_q;
      num_d       = num_q;
      pick_idle_s = pick_rr(req, last_q, 1'b1);
      pick_own_s  = pick_rr(req, owner_q, 1'b0);
      case (state_q)
         ST_IDLE: begin
            if (pick_idle_s[2]) begin
               state_d = ST_HOLD;
               gnt_d   = 3'b001 << pick_idle_s[1:0];
               owner_d = pick_idle_s[1:0];
               last_d  = pick_idle_s[1:0];
               cnt_d   = HOLD_LOAD;
               num_d   = sel_data(pick_idle_s[1:0], data0, data1, data2);
            end else begin
               gnt_d = 3'b000;
               num_d = 16'h0000;
            end
         end
         ST_HOLD: begin
            // A released owner keeps the display, frozen on its last word.
            if (req[owner_q]) begin
               num_d = sel_data(owner_q, data0, data1, data2);
            end else begin
               num_d = num_q;
            end
            if (cnt_q == 32'd0) begin
               state_d = ST_OWN;
            end else begin
               cnt_d = cnt_q - 32'd1;
            end
         end
         ST_OWN: begin
            if (pick_own_s[2]) begin
               // Hand over directly to the next requester, no idle gap.
               state_d = ST_HOLD;
               gnt_d   = 3'b001 << pick_own_s[1:0];
               owner_d = pick_own_s[1:0];
               last_d  = pick_own_s[1:0];
               cnt_d   = HOLD_LOAD;
               num_d   = sel_data(pick_own_s[1:0], data0, data1, data2);
            end else if (req[owner_q]) begin
               num_d = sel_data(owner_q, data0, data1, data2);
            end else begin
               state_d = ST_IDLE;
               gnt_d   = 3'b000;
               num_d   = 16'h0000;
               cnt_d   = 32'd0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 3'b000;
            num_d   = 16'h0000;
            cnt_d   = 32'd0;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         gnt_q   <= 3'b000;
         owner_q <= 2'd0;
         last_q  <= 2'd2;
         cnt_q   <= 32'd0;
         num_q   <= 16'h0000;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         num_q   <= num_d;
      end
   end

   // Blank mask derived from the registered word so it always matches disp_num.
   always_comb begin
      blank_s = 4'b1111;
      if (state_q == ST_IDLE) begin
         blank_s = 4'b1111;
      end else if (LZB) begin
         blank_s[3] = (num_q[15:12] == 4'h0);
         blank_s[2] = (num_q[15:8]  == 8'h00);
         blank_s[1] = (num_q[15:4]  == 12'h000);
         blank_s[0] = 1'b0;
      end else begin
         blank_s = 4'b0000;
      end
   end

   assign gnt        = gnt_q;
   assign disp_num   = num_q;
   assign disp_blank = blank_s;
   assign busy       = (state_q != ST_IDLE);

endmodule
